// File: rtl/fifo_bh_rr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_bh_rr_wr_arbiter
//
// Burst-holding round-robin write arbiter in front of a FIFO, plus a thin
// valid/ready adapter on the FIFO read side.
//
// Write side: while IDLE the arbiter picks the next requester after the
// previous burst owner (round robin), spends one bubble cycle arbitrating,
// then holds the grant in BURST until the owner's last beat is accepted.
// Beats are forwarded combinationally to the FIFO and are throttled by the
// FIFO almost-full flag.
//
// Ports
//   clk                 clock, all state on rising edge
//   reset_n             asynchronous active-low reset
//   req_valid_i         per-requester beat valid
//   req_last_i          per-requester last beat of burst (qualified by valid)
//   req_data_i          requester k data at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o         per-requester beat accept
//   grant_o             one-hot burst owner, all-zero when idle
//   fifo_wren_o         FIFO write enable
//   fifo_wdata_o        FIFO write data (owner's data slice)
//   fifo_almost_full_i  FIFO almost-full flag, blocks writes
//   fifo_empty_i        FIFO empty flag
//   fifo_rdata_i        FIFO head data
//   fifo_rden_o         FIFO pop
//   out_valid_o         downstream valid
//   out_ready_i         downstream ready
//   out_data_o          downstream data
//   beat_cnt_o          beats written to the FIFO since reset (wraps)
// ---------------------------------------------------------------------------
module fifo_bh_rr_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int NUM_REQ_LG2 = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            fifo_wren_o,
    output logic [DATA_WIDTH-1:0]           fifo_wdata_o,
    input  logic                            fifo_almost_full_i,
    input  logic                            fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]           fifo_rdata_i,
    output logic                            fifo_rden_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DATA_WIDTH-1:0]           out_data_o,
    output logic [15:0]                     beat_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ_LG2-1:0] owner_q, owner_d;
    logic [NUM_REQ_LG2-1:0] last_q, last_d;
    logic [15:0]            beat_cnt_q;

    logic [NUM_REQ_LG2-1:0] pick;
    logic [NUM_REQ_LG2-1:0] scan_idx;
    logic                   pick_found;

    logic                   owner_valid;
    logic                   owner_last;
    logic [DATA_WIDTH-1:0]  owner_data;

    // -----------------------------------------------------------------------
    // Round-robin pick: scan last_q+1 .. last_q+NUM_REQ. NUM_REQ is a power
    // of two, so truncating the sum to NUM_REQ_LG2 bits gives the modulo.
    // -----------------------------------------------------------------------
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            scan_idx = last_q + NUM_REQ_LG2'(i);
            if (!pick_found && req_valid_i[scan_idx]) begin
                pick       = scan_idx;
                pick_found = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Owner's request lane.
    // -----------------------------------------------------------------------
    assign owner_valid = req_valid_i[owner_q];
    assign owner_last  = req_last_i[owner_q];

    always_comb begin
        owner_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner_q == NUM_REQ_LG2'(k)) begin
                owner_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and write-side outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_o     = '0;
        req_ready_o = '0;
        fifo_wren_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Arbitration bubble: nothing is accepted in this cycle.
                if (pick_found) begin
                    owner_d = pick;
                    state_d = BURST;
                end
            end
            BURST: begin
                grant_o[owner_q]     = 1'b1;
                req_ready_o[owner_q] = !fifo_almost_full_i;
                fifo_wren_o          = owner_valid && !fifo_almost_full_i;
                // Only an accepted last beat ends the burst; valid gaps from
                // the owner simply hold the grant.
                if (fifo_wren_o && owner_last) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_wdata_o = owner_data;

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            // Point at the top requester so requester 0 is scanned first.
            last_q  <= NUM_REQ_LG2'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
        end else if (fifo_wren_o) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
        end
    end

    assign beat_cnt_o = beat_cnt_q;

    // -----------------------------------------------------------------------
    // Read side: independent, purely combinational valid/ready adapter.
    // -----------------------------------------------------------------------
    assign out_valid_o = !fifo_empty_i;
    assign out_data_o  = fifo_rdata_i;
    assign fifo_rden_o = out_valid_o && out_ready_i;

endmodule

// File: tb/tb_fifo_bh_rr_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_bh_rr_wr_arbiter
//
// Self-checking bench for fifo_bh_rr_wr_arbiter. Requesters are modelled as
// per-lane beat lists; every beat written to the FIFO is checked against a
// queue of expected beats filled in the order the bursts should be granted.
// ---------------------------------------------------------------------------
module tb_fifo_bh_rr_wr_arbiter;

    localparam int NR  = 4;
    localparam int NRL = 2;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_last_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR-1:0]     grant_o;
    logic              fifo_wren_o;
    logic [DW-1:0]     fifo_wdata_o;
    logic              fifo_almost_full_i;
    logic              fifo_empty_i;
    logic [DW-1:0]     fifo_rdata_i;
    logic              fifo_rden_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DW-1:0]     out_data_o;
    logic [15:0]       beat_cnt_o;

    always #5 clk = ~clk;

    fifo_bh_rr_wr_arbiter #(
        .NUM_REQ     (NR),
        .NUM_REQ_LG2 (NRL),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .req_valid_i        (req_valid_i),
        .req_last_i         (req_last_i),
        .req_data_i         (req_data_i),
        .req_ready_o        (req_ready_o),
        .grant_o            (grant_o),
        .fifo_wren_o        (fifo_wren_o),
        .fifo_wdata_o       (fifo_wdata_o),
        .fifo_almost_full_i (fifo_almost_full_i),
        .fifo_empty_i       (fifo_empty_i),
        .fifo_rdata_i       (fifo_rdata_i),
        .fifo_rden_o        (fifo_rden_o),
        .out_valid_o        (out_valid_o),
        .out_ready_i        (out_ready_i),
        .out_data_o         (out_data_o),
        .beat_cnt_o         (beat_cnt_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Requester beat lists: {last, data}
    logic [DW:0]   beats [NR][16];
    int            head  [NR];
    int            tail  [NR];
    logic [NR-1:0] en;

    logic [DW-1:0] exp_q [$];

    // Scoreboard: every FIFO write must be the next expected beat.
    always @(negedge clk) begin
        if (reset_n && fifo_wren_o) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL sb_extra_write: got %h, expected no write", fifo_wdata_o);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (fifo_wdata_o !== e) begin
                    mismatched++;
                    $display("FAIL sb_wdata: got %h, expected %h", fifo_wdata_o, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Stimulus plumbing
    // ---------------------------------------------------------------------
    task automatic drive();
        for (int k = 0; k < NR; k++) begin
            if (head[k] < tail[k]) begin
                req_valid_i[k]         = en[k];
                req_last_i[k]          = beats[k][head[k]][DW];
                req_data_i[k*DW +: DW] = beats[k][head[k]][DW-1:0];
            end else begin
                req_valid_i[k]         = 1'b0;
                req_last_i[k]          = 1'b0;
                req_data_i[k*DW +: DW] = '0;
            end
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    // One clock: handshake sampled at the negedge, lists advanced after the
    // posedge, new inputs driven, outputs settled.
    task automatic step();
        logic [NR-1:0] acc;
        drive();
        @(negedge clk);
        acc = req_valid_i & req_ready_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc[k] && reset_n) head[k]++;
        end
        drive();
        #1;
    endtask

    task automatic queue_burst(input int k, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            beats[k][tail[k]] = {(i == n - 1), DW'(base + i)};
            tail[k]++;
        end
    endtask

    task automatic expect_burst(input int n, input int base);
        for (int i = 0; i < n; i++) exp_q.push_back(DW'(base + i));
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < NR; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        en = '1;
        exp_q.delete();
    endtask

    function automatic bit all_done();
        bit d;
        d = 1'b1;
        for (int k = 0; k < NR; k++) if (head[k] != tail[k]) d = 1'b0;
        return d;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        fifo_almost_full_i = 1'b0;
        clear_reqs();
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive();
        #1;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (!all_done() && cyc < 200) begin
            step();
            cyc++;
        end
        compared++;
        if (!all_done() || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, exp_q.size());
        end
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        queue_burst(0, 1, 'h10);
        fifo_empty_i = 1'b0;
        out_ready_i  = 1'b1;
        fifo_rdata_i = 32'hA5A5_0001;
        step();
        step();
        compared++;
        if (grant_o !== 4'b0000) begin
            mismatched++;
            $display("FAIL rst_grant: got %b, expected 0000", grant_o);
        end
        compared++;
        if (req_ready_o !== 4'b0000 || fifo_wren_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_ready_wren: got %b/%b, expected 0000/0", req_ready_o, fifo_wren_o);
        end
        compared++;
        if (beat_cnt_o !== 16'd0) begin
            mismatched++;
            $display("FAIL rst_beat_cnt: got %0d, expected 0", beat_cnt_o);
        end
        compared++;
        if (fifo_rden_o !== 1'b1 || out_data_o !== 32'hA5A5_0001) begin
            mismatched++;
            $display("FAIL rst_read_side: got rden=%b data=%h, expected 1/a5a50001", fifo_rden_o, out_data_o);
        end
    endtask

    task automatic test_first_grant();
        do_reset();
        queue_burst(1, 3, 'h100);
        queue_burst(3, 2, 'h300);
        expect_burst(3, 'h100);
        expect_burst(2, 'h300);
        release_reset();
        compared++;
        if (grant_o !== 4'b0000 || req_ready_o !== 4'b0000) begin
            mismatched++;
            $display("FAIL first_idle: got grant=%b ready=%b, expected 0000/0000", grant_o, req_ready_o);
        end
        step();
        compared++;
        if (grant_o !== 4'b0010 || req_ready_o !== 4'b0010) begin
            mismatched++;
            $display("FAIL first_grant: got grant=%b ready=%b, expected 0010/0010", grant_o, req_ready_o);
        end
        drain("first");
        compared++;
        if (beat_cnt_o !== 16'd5) begin
            mismatched++;
            $display("FAIL first_beat_cnt: got %0d, expected 5", beat_cnt_o);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] gseq [8];
        logic [NR-1:0] gexp [8];
        logic [NR-1:0] prev;
        int ngr;
        int cycles;
        gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NR; k++) begin
                queue_burst(k, 2, 'h1000 + k * 'h100 + b * 'h10);
                expect_burst(2, 'h1000 + k * 'h100 + b * 'h10);
            end
        end
        release_reset();
        prev   = grant_o;
        ngr    = 0;
        cycles = 0;
        for (int i = 0; i < 8; i++) gseq[i] = '0;
        while (!all_done() && cycles < 100) begin
            step();
            cycles++;
            if (grant_o != 0 && prev == 0) begin
                if (ngr < 8) gseq[ngr] = grant_o;
                ngr++;
            end
            prev = grant_o;
        end
        compared++;
        if (ngr != 8) begin
            mismatched++;
            $display("FAIL rr_burst_count: got %0d, expected 8", ngr);
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (gseq[i] !== gexp[i]) begin
                mismatched++;
                $display("FAIL rr_grant_%0d: got %b, expected %b", i, gseq[i], gexp[i]);
            end
        end
        compared++;
        if (cycles != 24) begin
            mismatched++;
            $display("FAIL rr_cycles: got %0d, expected 24", cycles);
        end
        compared++;
        if (beat_cnt_o !== 16'd16 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL rr_beat_cnt: got %0d (pending %0d), expected 16 (pending 0)", beat_cnt_o, exp_q.size());
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        queue_burst(0, 5, 'h2000);
        expect_burst(5, 'h2000);
        release_reset();
        step();
        step();
        fifo_almost_full_i = 1'b1;
        settle();
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (fifo_wren_o !== 1'b0 || req_ready_o !== 4'b0000 || grant_o !== 4'b0001) begin
                mismatched++;
                $display("FAIL af_stall_%0d: got wren=%b ready=%b grant=%b, expected 0/0000/0001",
                         i, fifo_wren_o, req_ready_o, grant_o);
            end
            if (i < 2) step();
        end
        step();
        fifo_almost_full_i = 1'b0;
        settle();
        compared++;
        if (fifo_wren_o !== 1'b1 || req_ready_o !== 4'b0001) begin
            mismatched++;
            $display("FAIL af_resume: got wren=%b ready=%b, expected 1/0001", fifo_wren_o, req_ready_o);
        end
        drain("af");
        compared++;
        if (beat_cnt_o !== 16'd5) begin
            mismatched++;
            $display("FAIL af_beat_cnt: got %0d, expected 5", beat_cnt_o);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        fifo_empty_i = 1'b0;
        out_ready_i  = 1'b1;
        queue_burst(2, 4, 'h3000);
        expect_burst(4, 'h3000);
        expect_burst(2, 'h3100);
        release_reset();
        step();
        queue_burst(0, 2, 'h3100);
        settle();
        compared++;
        if (grant_o !== 4'b0100) begin
            mismatched++;
            $display("FAIL np_hold_0: got %b, expected 0100", grant_o);
        end
        step();
        compared++;
        if (fifo_wren_o !== 1'b1 || fifo_rden_o !== 1'b1) begin
            mismatched++;
            $display("FAIL np_wr_rd_same_cycle: got wren=%b rden=%b, expected 1/1", fifo_wren_o, fifo_rden_o);
        end
        en[2] = 1'b0;
        settle();
        compared++;
        if (grant_o !== 4'b0100 || fifo_wren_o !== 1'b0) begin
            mismatched++;
            $display("FAIL np_gap: got grant=%b wren=%b, expected 0100/0", grant_o, fifo_wren_o);
        end
        step();
        en[2] = 1'b1;
        settle();
        step();
        step();
        compared++;
        if (grant_o !== 4'b0100 || req_last_i[2] !== 1'b1) begin
            mismatched++;
            $display("FAIL np_hold_last: got grant=%b last=%b, expected 0100/1", grant_o, req_last_i[2]);
        end
        step();
        compared++;
        if (grant_o !== 4'b0000) begin
            mismatched++;
            $display("FAIL np_idle: got %b, expected 0000", grant_o);
        end
        step();
        compared++;
        if (grant_o !== 4'b0001) begin
            mismatched++;
            $display("FAIL np_next_grant: got %b, expected 0001", grant_o);
        end
        drain("np");
        compared++;
        if (beat_cnt_o !== 16'd6) begin
            mismatched++;
            $display("FAIL np_beat_cnt: got %0d, expected 6", beat_cnt_o);
        end
    endtask

    task automatic test_single_beat();
        int gcycles;
        do_reset();
        queue_burst(1, 1, 'h4000);
        expect_burst(1, 'h4000);
        release_reset();
        gcycles = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (grant_o != 0) gcycles++;
        end
        compared++;
        if (gcycles != 1) begin
            mismatched++;
            $display("FAIL single_burst_cycles: got %0d, expected 1", gcycles);
        end
        compared++;
        if (beat_cnt_o !== 16'd1 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL single_beat_cnt: got %0d, expected 1", beat_cnt_o);
        end
    endtask

    task automatic test_read_side();
        logic [2:0] rdy_seq;
        rdy_seq = 3'b101;
        fifo_empty_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out_ready_i  = rdy_seq[2 - i];
            fifo_rdata_i = DW'(32'hBEEF_0000 + i);
            #1;
            compared++;
            if (fifo_rden_o !== rdy_seq[2 - i] || out_valid_o !== 1'b1 || out_data_o !== fifo_rdata_i) begin
                mismatched++;
                $display("FAIL rd_toggle_%0d: got rden=%b valid=%b data=%h, expected %b/1/%h",
                         i, fifo_rden_o, out_valid_o, out_data_o, rdy_seq[2 - i], fifo_rdata_i);
            end
        end
        fifo_empty_i = 1'b1;
        out_ready_i  = 1'b1;
        #1;
        compared++;
        if (fifo_rden_o !== 1'b0 || out_valid_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rd_empty: got rden=%b valid=%b, expected 0/0", fifo_rden_o, out_valid_o);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        queue_burst(0, 1, 'h5000);
        queue_burst(2, 4, 'h5100);
        expect_burst(1, 'h5000);
        expect_burst(4, 'h5100);
        release_reset();
        for (int i = 0; i < 5; i++) step();
        compared++;
        if (beat_cnt_o !== 16'd3 || grant_o !== 4'b0100) begin
            mismatched++;
            $display("FAIL mid_pre: got cnt=%0d grant=%b, expected 3/0100", beat_cnt_o, grant_o);
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if (grant_o !== 4'b0000 || req_ready_o !== 4'b0000 || fifo_wren_o !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_async: got grant=%b ready=%b wren=%b, expected 0000/0000/0",
                     grant_o, req_ready_o, fifo_wren_o);
        end
        compared++;
        if (beat_cnt_o !== 16'd0) begin
            mismatched++;
            $display("FAIL mid_beat_cnt: got %0d, expected 0", beat_cnt_o);
        end
        clear_reqs();
        queue_burst(1, 2, 'h5200);
        queue_burst(0, 1, 'h5300);
        expect_burst(1, 'h5300);
        expect_burst(2, 'h5200);
        step();
        release_reset();
        step();
        compared++;
        if (grant_o !== 4'b0001) begin
            mismatched++;
            $display("FAIL mid_post_grant: got %b, expected 0001", grant_o);
        end
        drain("mid");
        compared++;
        if (beat_cnt_o !== 16'd3) begin
            mismatched++;
            $display("FAIL mid_post_cnt: got %0d, expected 3", beat_cnt_o);
        end
    endtask

    initial begin
        reset_n            = 1'b0;
        req_valid_i        = '0;
        req_last_i         = '0;
        req_data_i         = '0;
        fifo_almost_full_i = 1'b0;
        fifo_empty_i       = 1'b1;
        fifo_rdata_i       = '0;
        out_ready_i        = 1'b0;
        clear_reqs();

        test_reset();
        test_first_grant();
        test_round_robin();
        test_almost_full();
        test_no_preempt();
        test_single_beat();
        test_read_side();
        test_reset_mid_burst();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_bh_rr_wr_arbiter.md
FIFO_BH_RR_WR_ARBITER -- requirements
Module: fifo_bh_rr_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (power of two, 2..16).
REQ-002 Parameter NUM_REQ_LG2, default 2, log2(NUM_REQ).
REQ-003 Parameter DATA_WIDTH, default 32, beat width; equals the attached FIFO data width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 req_valid_i  input  NUM_REQ  per-requester beat valid.
REQ-007 req_last_i  input  NUM_REQ  per-requester last beat of burst; qualified by req_valid_i.
REQ-008 req_data_i  input  NUM_REQ*DATA_WIDTH  requester k data at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready_o  output  NUM_REQ  per-requester beat accept.
REQ-010 grant_o  output  NUM_REQ  one-hot current burst owner; all-zero when idle.
REQ-011 fifo_wren_o  output  1  FIFO write enable.
REQ-012 fifo_wdata_o  output  DATA_WIDTH  FIFO write data.
REQ-013 fifo_almost_full_i  input  1  FIFO almost-full flag.
REQ-014 fifo_empty_i  input  1  FIFO empty flag.
REQ-015 fifo_rdata_i  input  DATA_WIDTH  FIFO head data.
REQ-016 fifo_rden_o  output  1  FIFO read enable (pop).
REQ-017 out_valid_o / out_ready_i / out_data_o  output/input/output  1/1/DATA_WIDTH  downstream valid-ready port.
REQ-018 beat_cnt_o  output  16  total beats written to the FIFO since reset.

Function
REQ-019 The block SHALL implement a two-state FSM: IDLE, BURST; owner register owner_q (NUM_REQ_LG2 bits); priority pointer last_q (NUM_REQ_LG2 bits).
REQ-020 IDLE: if any req_valid_i bit set, the block SHALL select the first set bit scanning last_q+1, last_q+2, ... modulo NUM_REQ, load owner_q, and enter BURST next cycle; else remain IDLE.
REQ-021 IDLE: req_ready_o SHALL be all-zero, fifo_wren_o 0, grant_o all-zero (one-cycle arbitration bubble per burst).
REQ-022 BURST: grant_o SHALL be one-hot at owner_q; req_ready_o[owner_q] = !fifo_almost_full_i; all other ready bits 0.
REQ-023 BURST: fifo_wren_o SHALL equal req_valid_i[owner_q] && !fifo_almost_full_i, combinational, zero added latency; fifo_wdata_o = owner slice of req_data_i.
REQ-024 A beat SHALL be accepted only when fifo_wren_o=1; no beat written while fifo_almost_full_i=1.
REQ-025 On an accepted beat with req_last_i[owner_q]=1 the block SHALL set last_q<=owner_q and return to IDLE; otherwise stay in BURST regardless of owner valid gaps.
REQ-026 Ownership SHALL NOT change mid-burst even if other requesters assert valid.
REQ-027 Read side: out_valid_o = !fifo_empty_i; out_data_o = fifo_rdata_i; fifo_rden_o = out_valid_o && out_ready_i; never pop when empty.
REQ-028 Write and read sides SHALL operate independently; simultaneous fifo_wren_o and fifo_rden_o in one cycle allowed.
REQ-029 beat_cnt_o SHALL increment by 1 per accepted beat and wrap 0xFFFF->0x0000.
REQ-030 A single-beat burst (valid and last on first beat) SHALL occupy exactly one BURST cycle when not almost-full.

Reset
REQ-031 On reset_n low the block SHALL asynchronously force: state IDLE, owner_q 0, last_q NUM_REQ-1 (requester 0 highest priority first), beat_cnt_o 0.
REQ-032 During reset, grant_o, req_ready_o, fifo_wren_o SHALL be 0; read-side outputs follow fifo_empty_i/out_ready_i combinationally.
REQ-033 Reset mid-burst SHALL abandon the burst; after release the next grant follows REQ-031 priority.

Verification
REQ-034 Reset release, req_valid_i=4'b1010, no last: cycle 1 IDLE, cycle 2 grant_o=4'b0010, req_ready_o=4'b0010.
REQ-035 All four requesters issue repeated 2-beat bursts: grants ordered 0,1,2,3,0; 3 cycles per burst; beat_cnt_o=16 after 8 bursts.
REQ-036 Owner mid-burst, fifo_almost_full_i held 1 for 3 cycles: fifo_wren_o=0, req_ready_o=0 for those cycles; burst resumes, no beat lost or duplicated.
REQ-037 Requester 2 owns burst, requester 0 asserts valid: grant stays 4'b0100 until req 2 last accepted, then IDLE, then grant 4'b0001.
REQ-038 fifo_empty_i=0, out_ready_i toggled 1,0,1: fifo_rden_o=1,0,1; fifo_empty_i=1 with out_ready_i=1: fifo_rden_o=0.
REQ-039 Assert reset_n low in BURST with 2 beats written: outputs zero immediately, beat_cnt_o=0; post-release first grant goes to lowest-index valid requester.
